// File: rtl/uart_rx_core.sv
// UART receiver core: 16x oversampled, majority-voted bit recovery into a
// one-entry holding register with parity/frame/overrun status.
module uart_rx_core #(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int OVS         = 16
) (
    input  logic        clk,
    input  logic        arst_n,
    input  logic        rx,
    input  logic        cfg_active,
    input  logic [1:0]  cfg_frame_size,
    input  logic [1:0]  cfg_parity,
    input  logic        cfg_stop2,
    input  logic [3:0]  cfg_baud_sel,
    input  logic        rx_ack,
    input  logic        err_clr,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        parity_err,
    output logic        frame_err,
    output logic        overrun,
    output logic        rx_busy,
    output logic [11:0] st_rdata
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP1     = 3'd4,
        STOP2     = 3'd5,
        WAIT_IDLE = 3'd6
    } state_t;

    function automatic logic [31:0] calc_div(input int baud);
        int d;
        d = CLK_FREQ_HZ / (OVS * baud);
        return (d < 1) ? 32'd1 : 32'(d);
    endfunction

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    function automatic logic xor8(input logic [7:0] d);
        return ^d;
    endfunction

    localparam logic [31:0] DIV_TAB [16] = '{
        calc_div(300),    calc_div(600),    calc_div(1200),   calc_div(2400),
        calc_div(4800),   calc_div(9600),   calc_div(14400),  calc_div(19200),
        calc_div(28800),  calc_div(38400),  calc_div(57600),  calc_div(115200),
        calc_div(230400), calc_div(460800), calc_div(921600), calc_div(115200)
    };

    logic        rx_meta_r, rx_sync_r, rx_prev_r;
    state_t      state_r;
    logic        busy_r;
    logic [31:0] tick_cnt_r;
    logic [3:0]  phase_r;
    logic [2:0]  bit_cnt_r;
    logic [7:0]  shreg_r;
    logic        s7_r, s8_r;
    logic        pe_r, fe_r;
    logic [1:0]  fs_r, par_r;
    logic        stop2_r;
    logic [3:0]  baud_r;
    logic [7:0]  data_r;
    logic        valid_r, perr_r, ferr_r, ovr_r;

    logic [31:0] div_s;
    logic        tick_s, mid_s, bit_s, final_s, load_s;
    logic        frame_fe_s, par_en_s, last_bit_s;
    logic [7:0]  load_data_s;

    assign div_s       = DIV_TAB[baud_r];
    assign tick_s      = (state_r != IDLE) && (state_r != WAIT_IDLE) && (tick_cnt_r == div_s - 32'd1);
    assign mid_s       = tick_s && (phase_r == 4'd9);
    assign bit_s       = maj3(s7_r, s8_r, rx_sync_r);
    assign final_s     = mid_s && (((state_r == STOP1) && !stop2_r) || (state_r == STOP2));
    assign load_s      = final_s && cfg_active;
    assign frame_fe_s  = fe_r | ~bit_s;
    assign par_en_s    = (par_r == 2'b01) || (par_r == 2'b10);
    assign last_bit_s  = (bit_cnt_r == (3'd4 + {1'b0, fs_r}));
    // Bits arrive LSB first into the top of shreg_r; short frames are right-justified here.
    assign load_data_s = shreg_r >> (2'd3 - fs_r);

    // Two-flop synchroniser plus previous-sample register for edge detection
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
            rx_prev_r <= 1'b1;
        end else begin
            rx_meta_r <= rx;
            rx_sync_r <= rx_meta_r;
            rx_prev_r <= rx_sync_r;
        end
    end

    // Receive FSM with oversampling counters and per-frame configuration latch
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_r    <= IDLE;
            busy_r     <= 1'b0;
            tick_cnt_r <= 32'd0;
            phase_r    <= 4'd0;
            bit_cnt_r  <= 3'd0;
            shreg_r    <= 8'd0;
            s7_r       <= 1'b1;
            s8_r       <= 1'b1;
            pe_r       <= 1'b0;
            fe_r       <= 1'b0;
            fs_r       <= 2'd0;
            par_r      <= 2'd0;
            stop2_r    <= 1'b0;
            baud_r     <= 4'd0;
        end else if (!cfg_active) begin
            state_r    <= IDLE;
            busy_r     <= 1'b0;
            tick_cnt_r <= 32'd0;
            phase_r    <= 4'd0;
            bit_cnt_r  <= 3'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    tick_cnt_r <= 32'd0;
                    phase_r    <= 4'd0;
                    if (rx_prev_r && !rx_sync_r) begin
                        state_r   <= START;
                        busy_r    <= 1'b1;
                        bit_cnt_r <= 3'd0;
                        shreg_r   <= 8'd0;
                        pe_r      <= 1'b0;
                        fe_r      <= 1'b0;
                        fs_r      <= cfg_frame_size;
                        par_r     <= cfg_parity;
                        stop2_r   <= cfg_stop2;
                        baud_r    <= cfg_baud_sel;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                WAIT_IDLE: begin
                    if (rx_sync_r) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        state_r <= WAIT_IDLE;
                    end
                end
                default: begin
                    if (tick_s) begin
                        tick_cnt_r <= 32'd0;
                        phase_r    <= phase_r + 4'd1;
                        if (phase_r == 4'd7) s7_r <= rx_sync_r;
                        if (phase_r == 4'd8) s8_r <= rx_sync_r;
                    end else begin
                        tick_cnt_r <= tick_cnt_r + 32'd1;
                    end
                    if (mid_s) begin
                        case (state_r)
                            START: begin
                                if (bit_s) begin
                                    state_r <= IDLE;
                                    busy_r  <= 1'b0;
                                end else begin
                                    state_r <= DATA;
                                end
                            end
                            DATA: begin
                                shreg_r   <= {bit_s, shreg_r[7:1]};
                                bit_cnt_r <= bit_cnt_r + 3'd1;
                                if (last_bit_s) state_r <= par_en_s ? PARITY : STOP1;
                            end
                            PARITY: begin
                                pe_r    <= xor8(shreg_r) ^ bit_s ^ (par_r == 2'b10);
                                state_r <= STOP1;
                            end
                            STOP1, STOP2: begin
                                fe_r <= frame_fe_s;
                                if ((state_r == STOP1) && stop2_r) begin
                                    state_r <= STOP2;
                                end else if (frame_fe_s) begin
                                    state_r <= WAIT_IDLE;
                                end else begin
                                    state_r <= IDLE;
                                    busy_r  <= 1'b0;
                                end
                            end
                            default: begin
                                state_r <= IDLE;
                                busy_r  <= 1'b0;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    // Holding register, per-frame error flags and sticky overrun
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            data_r  <= 8'd0;
            valid_r <= 1'b0;
            perr_r  <= 1'b0;
            ferr_r  <= 1'b0;
            ovr_r   <= 1'b0;
        end else begin
            if (load_s) begin
                data_r  <= load_data_s;
                perr_r  <= pe_r;
                ferr_r  <= frame_fe_s;
                valid_r <= 1'b1;
            end else if (rx_ack) begin
                valid_r <= 1'b0;
            end
            if (load_s && valid_r && !rx_ack) begin
                ovr_r <= 1'b1;
            end else if (err_clr) begin
                ovr_r <= 1'b0;
            end
        end
    end

    assign rx_data    = data_r;
    assign rx_valid   = valid_r;
    assign parity_err = perr_r;
    assign frame_err  = ferr_r;
    assign overrun    = ovr_r;
    assign rx_busy    = busy_r;
    assign st_rdata   = {data_r, busy_r, ovr_r, ferr_r, perr_r};

endmodule
